// File: rtl/bt_pkg.sv
// Shared definitions for the balanced-ternary interface blocks.
// Trit codes, trit/state types, modulus of a 2-trit word and a
// single-trit decode helper.
package bt_pkg;

   typedef logic [1:0] trit_t;

   localparam trit_t TRIT_NEG  = 2'b01;
   localparam trit_t TRIT_ZERO = 2'b11;
   localparam trit_t TRIT_POS  = 2'b10;
   localparam trit_t TRIT_BAD  = 2'b00;

   localparam int BT2_MOD = 9;

   typedef enum logic {IDLE, TRACK} state_t;

   // Invalid code decodes to 0; callers flag it separately.
   function automatic logic signed [1:0] trit_to_int(input trit_t t);
      logic signed [1:0] r;
      case (t)
         TRIT_NEG: r = 2'sb11;
         TRIT_POS: r = 2'sb01;
         default:  r = 2'sb00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/bt2_to_bin.sv
// Combinational 2-trit balanced-ternary to signed binary decode.
// Ports:
//   trit_hi, trit_lo : MS / LS trit codes
//   val              : 3*hi + lo, range -4..+4
//   invalid          : either trit carries the unused code 00
module bt2_to_bin
   import bt_pkg::*;
(
   input  logic [1:0]        trit_hi,
   input  logic [1:0]        trit_lo,
   output logic signed [3:0] val,
   output logic              invalid
);

   logic signed [1:0] hi_t;
   logic signed [1:0] lo_t;
   logic signed [3:0] hi_s;
   logic signed [3:0] lo_s;

   assign hi_t = trit_to_int(trit_hi);
   assign lo_t = trit_to_int(trit_lo);
   assign hi_s = {{2{hi_t[1]}}, hi_t};
   assign lo_s = {{2{lo_t[1]}}, lo_t};

   // 3*hi as shift-and-add keeps everything 4 bits wide
   assign val     = (hi_s <<< 1) + hi_s + lo_s;
   assign invalid = (trit_hi == TRIT_BAD) || (trit_lo == TRIT_BAD);

endmodule

// File: rtl/bt_count_decoder.sv
// Receiver for the 2-trit balanced-ternary counter. Decodes each sample,
// follows single steps across the +4/-4 wrap to build an extended signed
// count, and presents results on a valid/ready port.
// Ports:
//   clock, reset         : clock, synchronous active-high reset
//   trit_hi, trit_lo     : counter DataOut trits
//   sample_en, load_seen : take a sample / sample follows a counter Load
//   out_valid, out_ready : result handshake
//   out_val, out_ext     : decoded sample, extended count
//   out_dir              : step as a trit (01 down, 11 none, 10 up)
//   err_code, err_step, dropped, ovf : sticky flags, cleared by clr_err
//
// state | meaning
// IDLE  | no reference sample yet; next valid sample seeds the count
// TRACK | count follows +-1 steps; larger jumps resynchronise
module bt_count_decoder
   import bt_pkg::*;
#(
   parameter int EXT_W = 12
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [1:0]              trit_hi,
   input  logic [1:0]              trit_lo,
   input  logic                    sample_en,
   input  logic                    load_seen,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [3:0]       out_val,
   output logic signed [EXT_W-1:0] out_ext,
   output logic [1:0]              out_dir,
   output logic                    err_code,
   output logic                    err_step,
   output logic                    dropped,
   output logic                    ovf,
   input  logic                    clr_err
);

   localparam logic signed [EXT_W-1:0] EXT_MAX = {1'b0, {(EXT_W-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] EXT_MIN = {1'b1, {(EXT_W-1){1'b0}}};
   localparam logic signed [EXT_W-1:0] EXT_ONE = {{(EXT_W-1){1'b0}}, 1'b1};
   localparam logic signed [4:0]       MOD5    = 5'(BT2_MOD);

   state_t                  state, state_nxt;
   logic signed [3:0]       prev;
   logic signed [EXT_W-1:0] ext_cnt, ext_nxt, v_ext;
   logic signed [3:0]       v;
   logic                    v_bad;
   logic                    take;
   logic signed [4:0]       diff_raw, diff;
   logic [1:0]              dir_nxt;
   logic                    step_err, sat_hit;

   bt2_to_bin u_dec (
      .trit_hi (trit_hi),
      .trit_lo (trit_lo),
      .val     (v),
      .invalid (v_bad)
   );

   assign take     = sample_en && !v_bad;
   assign v_ext    = {{(EXT_W-4){v[3]}}, v};
   assign diff_raw = {v[3], v} - {prev[3], prev};

   // Fold the raw difference (-8..+8) into -4..+4 so a wrap reads as +-1
   always_comb begin
      diff = diff_raw;
      if (diff_raw > 5'sd4)
         diff = diff_raw - MOD5;
      else if (diff_raw < -5'sd4)
         diff = diff_raw + MOD5;
   end

   always_comb begin
      state_nxt = state;
      ext_nxt   = ext_cnt;
      dir_nxt   = TRIT_ZERO;
      step_err  = 1'b0;
      sat_hit   = 1'b0;
      if (take) begin
         case (state)
            IDLE: begin
               ext_nxt   = v_ext;
               state_nxt = TRACK;
            end
            TRACK: begin
               if (load_seen) begin
                  ext_nxt = v_ext;
               end else if (diff == 5'sd1) begin
                  dir_nxt = TRIT_POS;
                  if (ext_cnt == EXT_MAX) sat_hit = 1'b1;
                  else                    ext_nxt = ext_cnt + EXT_ONE;
               end else if (diff == -5'sd1) begin
                  dir_nxt = TRIT_NEG;
                  if (ext_cnt == EXT_MIN) sat_hit = 1'b1;
                  else                    ext_nxt = ext_cnt - EXT_ONE;
               end else if (diff != 5'sd0) begin
                  step_err = 1'b1;
                  ext_nxt  = v_ext;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prev      <= '0;
         ext_cnt   <= '0;
         out_valid <= 1'b0;
         out_val   <= '0;
         out_ext   <= '0;
         out_dir   <= TRIT_ZERO;
         err_code  <= 1'b0;
         err_step  <= 1'b0;
         dropped   <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         if (take) begin
            prev    <= v;
            ext_cnt <= ext_nxt;
         end
         // Blocked results are lost, but tracking above still advances
         if (take && (!out_valid || out_ready)) begin
            out_valid <= 1'b1;
            out_val   <= v;
            out_ext   <= ext_nxt;
            out_dir   <= dir_nxt;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         // A new error in the clearing cycle takes priority
         err_code <= (sample_en && v_bad) || (err_code && !clr_err);
         err_step <= step_err || (err_step && !clr_err);
         dropped  <= (take && out_valid && !out_ready) || (dropped && !clr_err);
         ovf      <= sat_hit || (ovf && !clr_err);
      end
   end

endmodule

// File: tb/tb_bt_count_decoder.sv
module tb_bt_count_decoder;

   localparam int EXT_W = 12;
   localparam logic [1:0] N = 2'b01, Z = 2'b11, P = 2'b10, B = 2'b00;

   logic                    clock = 1'b0;
   logic                    reset = 1'b1;
   logic [1:0]              trit_hi = Z, trit_lo = Z;
   logic                    sample_en = 1'b0, load_seen = 1'b0;
   logic                    out_ready = 1'b1, clr_err = 1'b0;
   logic                    out_valid;
   logic signed [3:0]       out_val;
   logic signed [EXT_W-1:0] out_ext;
   logic [1:0]              out_dir;
   logic                    err_code, err_step, dropped, ovf;

   int n_cmp = 0;
   int n_bad = 0;

   bt_count_decoder #(.EXT_W(EXT_W)) dut (
      .clock     (clock),
      .reset     (reset),
      .trit_hi   (trit_hi),
      .trit_lo   (trit_lo),
      .sample_en (sample_en),
      .load_seen (load_seen),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_val   (out_val),
      .out_ext   (out_ext),
      .out_dir   (out_dir),
      .err_code  (err_code),
      .err_step  (err_step),
      .dropped   (dropped),
      .ovf       (ovf),
      .clr_err   (clr_err)
   );

   always #5 clock = ~clock;

   initial begin
      #2ms;
      $display("FAIL watchdog: actual=still running required=finished");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       rst;
      logic [1:0] hi;
      logic [1:0] lo;
      logic       load;
      int         val;
      int         ext;
      logic [1:0] dir;
      logic       es;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string nm, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      sample_en = 1'b0;
      reset     = 1'b1;
      @(posedge clock); #1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   // Present one sample; outputs are checked 1 time unit after the capturing edge
   task automatic do_sample(input logic [1:0] hi, input logic [1:0] lo, input logic ld);
      @(negedge clock);
      trit_hi   = hi;
      trit_lo   = lo;
      load_seen = ld;
      sample_en = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic do_idle();
      @(negedge clock);
      sample_en = 1'b0;
      load_seen = 1'b0;
      @(posedge clock); #1;
   endtask

   function automatic int wrap9(input int x);
      return (((x % 9) + 13) % 9) - 4;
   endfunction

   function automatic logic [1:0] t_code(input int t);
      return (t > 0) ? P : (t < 0) ? N : Z;
   endfunction

   task automatic enc_sample(input int v);
      int h;
      h = (v >= 2) ? 1 : (v <= -2) ? -1 : 0;
      do_sample(t_code(h), t_code(v - 3 * h), 1'b0);
   endtask

   initial begin
      // rst, hi, lo, load, val, ext, dir, err_step
      vecs.push_back('{1'b1, Z, P, 1'b0,  1,  1, Z, 1'b0});
      vecs.push_back('{1'b0, Z, Z, 1'b0,  0,  0, N, 1'b0});
      vecs.push_back('{1'b1, P, P, 1'b0,  4,  4, Z, 1'b0});
      vecs.push_back('{1'b0, N, N, 1'b0, -4,  5, P, 1'b0});
      vecs.push_back('{1'b0, N, Z, 1'b0, -3,  6, P, 1'b0});
      vecs.push_back('{1'b0, N, P, 1'b0, -2,  7, P, 1'b0});
      vecs.push_back('{1'b0, Z, N, 1'b0, -1,  8, P, 1'b0});
      vecs.push_back('{1'b0, Z, Z, 1'b0,  0,  9, P, 1'b0});
      vecs.push_back('{1'b0, Z, P, 1'b0,  1, 10, P, 1'b0});
      vecs.push_back('{1'b0, P, N, 1'b0,  2, 11, P, 1'b0});
      vecs.push_back('{1'b0, P, Z, 1'b0,  3, 12, P, 1'b0});
      vecs.push_back('{1'b0, P, P, 1'b0,  4, 13, P, 1'b0});
      vecs.push_back('{1'b0, N, N, 1'b0, -4, 14, P, 1'b0});
      vecs.push_back('{1'b1, N, N, 1'b0, -4, -4, Z, 1'b0});
      vecs.push_back('{1'b0, P, P, 1'b0,  4, -5, N, 1'b0});
      vecs.push_back('{1'b1, Z, Z, 1'b0,  0,  0, Z, 1'b0});
      vecs.push_back('{1'b0, P, Z, 1'b0,  3,  3, Z, 1'b1});
      vecs.push_back('{1'b0, P, Z, 1'b0,  3,  3, Z, 1'b1});
      vecs.push_back('{1'b1, Z, Z, 1'b0,  0,  0, Z, 1'b0});
      vecs.push_back('{1'b0, P, Z, 1'b1,  3,  3, Z, 1'b0});
      vecs.push_back('{1'b0, Z, P, 1'b0,  1,  1, Z, 1'b1});

      // Reset state
      @(posedge clock); #1;
      @(posedge clock); #1;
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      check("rst_valid", out_valid, 0);
      check("rst_val", out_val, 0);
      check("rst_ext", out_ext, 0);
      check("rst_dir", out_dir, 2'b11);
      check("rst_flags", {err_code, err_step, dropped, ovf}, 0);

      // Table
      out_ready = 1'b1;
      foreach (vecs[i]) begin
         if (vecs[i].rst) do_reset();
         do_sample(vecs[i].hi, vecs[i].lo, vecs[i].load);
         check($sformatf("v%0d_valid", i), out_valid, 1);
         check($sformatf("v%0d_val", i), out_val, vecs[i].val);
         check($sformatf("v%0d_ext", i), out_ext, vecs[i].ext);
         check($sformatf("v%0d_dir", i), out_dir, vecs[i].dir);
         check($sformatf("v%0d_estep", i), err_step, vecs[i].es);
      end
      do_idle();
      check("tbl_drain_valid", out_valid, 0);

      // Backpressure: samples 0,+1,+2 while blocked, then +3 with ready
      do_reset();
      out_ready = 1'b0;
      do_sample(Z, Z, 1'b0);
      check("bp0_valid", out_valid, 1);
      check("bp0_dropped", dropped, 0);
      do_sample(Z, P, 1'b0);
      check("bp1_val", out_val, 0);
      check("bp1_dropped", dropped, 1);
      do_sample(P, N, 1'b0);
      check("bp2_val", out_val, 0);
      check("bp2_ext", out_ext, 0);
      out_ready = 1'b1;
      do_sample(P, Z, 1'b0);
      check("bp3_val", out_val, 3);
      check("bp3_ext", out_ext, 3);
      check("bp3_dir", out_dir, P);
      do_idle();
      check("bp_accept_valid", out_valid, 0);

      // Invalid code is ignored apart from err_code
      do_sample(Z, B, 1'b0);
      check("bad_err_code", err_code, 1);
      check("bad_valid", out_valid, 0);
      do_idle();
      @(negedge clock);
      clr_err = 1'b1;
      @(posedge clock); #1;
      @(negedge clock);
      clr_err = 1'b0;
      check("clr_err_code", err_code, 0);
      check("clr_dropped", dropped, 0);
      do_sample(P, P, 1'b0);
      check("after_bad_ext", out_ext, 4);
      check("after_bad_dir", out_dir, P);
      check("after_bad_estep", err_step, 0);
      clr_err = 1'b1;
      do_sample(B, Z, 1'b0);
      check("clr_vs_new_err", err_code, 1);
      do_idle();
      clr_err = 1'b0;

      // Reset with a pending result
      out_ready = 1'b0;
      do_sample(Z, P, 1'b0);
      check("midhs_valid", out_valid, 1);
      do_reset();
      check("midhs_rst_valid", out_valid, 0);
      check("midhs_rst_dir", out_dir, 2'b11);
      out_ready = 1'b1;
      do_sample(P, Z, 1'b0);
      check("midhs_seed_ext", out_ext, 3);
      check("midhs_seed_estep", err_step, 0);

      // Positive saturation
      do_reset();
      enc_sample(0);
      for (int k = 1; k <= 2047; k++) enc_sample(wrap9(k));
      check("satp_ext_at_max", out_ext, 2047);
      check("satp_ovf_before", ovf, 0);
      enc_sample(wrap9(2048));
      check("satp_ext_held", out_ext, 2047);
      check("satp_ovf", ovf, 1);
      check("satp_estep", err_step, 0);

      // Negative saturation
      do_reset();
      enc_sample(0);
      for (int k = 1; k <= 2048; k++) enc_sample(wrap9(-k));
      check("satn_ext_at_min", out_ext, -2048);
      check("satn_ovf_before", ovf, 0);
      enc_sample(wrap9(-2049));
      check("satn_ext_held", out_ext, -2048);
      check("satn_ovf", ovf, 1);
      check("satn_dir", out_dir, N);
      do_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bt_count_decoder.md
Name: bt_count_decoder

Overview:
- Receiving end of the 2-trit balanced-ternary counter interface.
- Samples the counter's DataOut trits and decodes each sample to a signed binary value in -4..+4.
- Tracks counter steps across wrap-around (+4↔-4) to keep an extended signed binary count.
- Presents each decoded result on a valid/ready output port to binary-side logic.

Parameters:
- EXT_W, 12: width of the extended two's-complement count (ext_cnt).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- trit_hi  in  2  counter DataOut MS trit.
- trit_lo  in  2  counter DataOut LS trit.
- sample_en  in  1  take a sample this cycle (driven from the counter clock edge detect).
- load_seen  in  1  counter Load was active for this sample; resynchronise, no step check.
- out_valid  out  1  decoded result pending.
- out_ready  in  1  consumer accepts the result when out_valid && out_ready.
- out_val  out  4  signed value of the sample, -4..+4.
- out_ext  out  EXT_W  signed extended count.
- out_dir  out  2  trit encoding of the step: 01 down, 11 none, 10 up.
- err_code  out  1  sticky: a sample contained code 00.
- err_step  out  1  sticky: a non-load sample stepped by more than ±1.
- dropped  out  1  sticky: a sample arrived while out_valid && !out_ready.
- ovf  out  1  sticky: ext_cnt saturated.
- clr_err  in  1  clears all sticky flags.

Behaviour:
- Trit encoding: 2'b01 = -1, 2'b11 = 0, 2'b10 = +1, 2'b00 = invalid.
- Sample value: v = 3*hi + lo.
- Reset:
  - out_valid=0, out_val=0, out_ext=0, out_dir=2'b11.
  - All sticky flags = 0.
  - FSM goes to IDLE, prev=0.
  - Reset in mid-handshake drops the pending result.
- FSM, IDLE (no reference sample yet):
  - On a valid sample, ext_cnt=v, out_dir=11, prev=v, go to TRACK.
- FSM, TRACK, per valid sample:
  - d = (v - prev) mod 9, mapped to -4..+4.
  - d = +1: ext_cnt += 1, dir=10. Covers the +4→-4 wrap.
  - d = -1: ext_cnt -= 1, dir=01. Covers the -4→+4 wrap.
  - d = 0: ext_cnt unchanged, dir=11.
  - |d| > 1 and load_seen=0: set err_step, ext_cnt = v (resync), dir=11.
  - load_seen=1: ext_cnt = v, dir=11, no step check, err_step untouched.
  - prev = v after every valid sample.
- Invalid code (either trit 00):
  - Set err_code.
  - Sample fully ignored: no state, prev, or output change.
- Saturation: ext_cnt saturates at -2^(EXT_W-1) and 2^(EXT_W-1)-1 and sets ovf. It is held at the limit and does not wrap.
- Output register, latency 1 cycle from sample_en to out_valid:
  - If out_valid=0, or out_valid && out_ready in the same cycle, load out_val/out_ext/out_dir and set out_valid.
  - If out_valid && !out_ready: set dropped. Output register unchanged. Internal tracking (prev, ext_cnt, FSM) still updates, so the next delivered out_ext is correct.
  - Accept with no new sample: out_valid drops to 0 next cycle.
  - Outputs stay stable while out_valid && !out_ready.
- clr_err together with a new error in the same cycle: the new error wins (flag = 1).
- sample_en=0: nothing changes except the handshake.

Decomposition:
- Shared package bt_pkg:
  - Trit codes TRIT_NEG=2'b01, TRIT_ZERO=2'b11, TRIT_POS=2'b10, TRIT_BAD=2'b00.
  - Trit typedef; FSM state enum {IDLE, TRACK}.
  - Function trit_to_int (2-bit code → signed 2-bit).
  - Constant BT2_MOD=9.
- Sub-module bt2_to_bin: combinational 2-trit → signed 4-bit decode plus invalid flag. Reused by other ternary-interface blocks.

Test Plan:
- Reset, then samples hi=11,lo=10 then hi=11,lo=11 → out_val=+1, out_ext=+1, then out_val=0, out_ext=0, dir=01.
- Up-wrap: start at +4 (10,10), next -4 (01,01) → out_ext=5, dir=10, err_step=0. Second wrap from +4 → out_ext=14.
- Down-wrap from -4 (01,01) to +4 (10,10) → out_ext=-5, dir=01.
- Jump 0→+3 without load → err_step=1, out_ext=3. Same jump with load_seen=1 → err_step stays 0.
- out_ready=0 across three samples 0,+1,+2 → out_val stays 0, dropped=1. Raise ready → next sample +3 gives out_ext=3.
- Sample trit_lo=00 → err_code=1, out_valid unchanged. clr_err → err_code=0.
